// File: rtl/console_pkg.sv
// Shared definitions for the MMIO console: TX state encoding, status word
// bit positions and the default program-finish code.
package console_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned ST_IDLE_BIT  = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_FINI_BIT  = 2;
  localparam int unsigned ST_COUNT_LSB = 8;

  localparam logic [31:0] FINI_CODE_DEFAULT = 32'h0002_0000;

  // Assemble the status word; unused bits read as zero.
  function automatic logic [31:0] pack_status(input logic idle, input logic full,
                                              input logic fini, input logic [7:0] count);
    logic [31:0] s;
    s = '0;
    s[ST_IDLE_BIT]         = idle;
    s[ST_FULL_BIT]         = full;
    s[ST_FINI_BIT]         = fini;
    s[ST_COUNT_LSB +: 8]   = count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Ports: clk_i/rst_ni (async active-low reset), push/din write side,
// pop/dout read side (dout shows the head, valid while !empty),
// full/empty flags and count (0..DEPTH).
// A push while full or a pop while empty is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console: bytes written to the device (addr[31]=1) are queued
// and sent out as 8N1 serial frames; writing FINI_CODE raises a sticky
// program-finished flag instead of queuing a character.
// Ports: clk_i, rst_ni (async active-low); dbus_* write channel
// (addr/wvalid/wdata in, wready out) and read channel (rvalid in, rdata/rack
// out, registered status word); uart_tx_o serial line; fini_o flag.
module mmio_console
  import console_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] FINI_CODE  = FINI_CODE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] dbus_addr_i,
  input  logic        dbus_wvalid_i,
  input  logic [31:0] dbus_wdata_i,
  output logic        dbus_wready_o,
  input  logic        dbus_rvalid_i,
  output logic [31:0] dbus_rdata_o,
  output logic        dbus_rack_o,
  output logic        uart_tx_o,
  output logic        fini_o
);

  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

  tx_state_e      state;
  logic [BW-1:0]  baud;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;

  logic           dev_sel;
  logic           is_fini;
  logic           wr_fire;
  logic           fifo_push;
  logic           fifo_pop;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [31:0]    status;
  logic           unused_addr_bits;

  assign dev_sel          = dbus_addr_i[31];
  assign unused_addr_bits = ^dbus_addr_i[30:0];

  // The finish code never needs FIFO space, so it is always accepted.
  assign is_fini       = (dbus_wdata_i == FINI_CODE);
  assign dbus_wready_o = is_fini || !fifo_full;
  assign wr_fire       = dbus_wvalid_i && dev_sel && dbus_wready_o;
  assign fifo_push     = wr_fire && !is_fini;
  assign fifo_pop      = (state == TX_IDLE) && !fifo_empty;

  assign status = pack_status(fifo_empty && (state == TX_IDLE), fifo_full,
                              fini_o, 8'(fifo_count));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (dbus_wdata_i[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fini_o <= 1'b0;
    end else if (wr_fire && is_fini) begin
      fini_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dbus_rack_o  <= 1'b0;
      dbus_rdata_o <= '0;
    end else begin
      dbus_rack_o  <= dbus_rvalid_i && dev_sel;
      dbus_rdata_o <= (dbus_rvalid_i && dev_sel) ? status : '0;
    end
  end

  // The line is registered alongside the state, so it changes on the same
  // edge the state enters START/DATA/STOP; each bit lasts CLK_DIV cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= TX_IDLE;
      baud      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          uart_tx_o <= 1'b1;
          if (!fifo_empty) begin
            shreg     <= fifo_dout;
            baud      <= BAUD_RELOAD;
            uart_tx_o <= 1'b0;
            state     <= TX_START;
          end
        end
        TX_START: begin
          if (baud == '0) begin
            baud      <= BAUD_RELOAD;
            bit_cnt   <= '0;
            uart_tx_o <= shreg[0];
            state     <= TX_DATA;
          end else begin
            baud <= baud - BW'(1);
          end
        end
        TX_DATA: begin
          if (baud == '0) begin
            baud <= BAUD_RELOAD;
            if (bit_cnt == 3'd7) begin
              uart_tx_o <= 1'b1;
              state     <= TX_STOP;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shreg     <= {1'b0, shreg[7:1]};
              uart_tx_o <= shreg[1];
            end
          end else begin
            baud <= baud - BW'(1);
          end
        end
        TX_STOP: begin
          if (baud == '0) begin
            state <= TX_IDLE;
          end else begin
            baud <= baud - BW'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule
